spi_master: RTL and testbench

Single-clock SPI master that forms complete frames toward the SPI slave: it accepts a 10-bit command word over a valid/ready handshake, drives `SS_n`/`MOSI`, and for read-data commands captures the 8-bit reply from `MISO`. It sits opposite the slave in the same clock domain. The slave samples `MOSI` on `clk`, so no SCK is generated. It serves as the stimulus-side endpoint for slave/RAM integration and system-level tests.

---
 rtl/spi_master_if.sv | 28 ++
 rtl/spi_master.sv | 124 ++++++++++++
 tb/tb_spi_master.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Command/response handshake between a frame requester and spi_master.
// The requester uses the master modport; spi_master itself uses the slave modport.
interface spi_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data,
    input  busy
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready,
    output rsp_valid,
    output rsp_data,
    output busy
  );
endinterface

// File: rtl/spi_master.sv
// Clock-synchronous SPI master: serialises a select bit plus a 10-bit command on MOSI
// under SS_n and, for read-data commands, shifts an 8-bit reply in from MISO.
module spi_master #(
  parameter int unsigned RD_GAP = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.slave  cmd,
  output logic         SS_n,
  output logic         MOSI,
  input  logic         MISO
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, RECV} state_t;

  localparam logic [3:0] SEND_LAST_BIT = 4'd10;
  localparam logic [3:0] SEND_LAST     = 4'd11;
  localparam logic [3:0] RECV_LAST     = 4'd8;
  localparam logic [3:0] GAP_LAST      = 4'((RD_GAP == 0) ? 0 : RD_GAP - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  cmd_q, cmd_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic [10:0] frame;

  // Pins are registered, so each state drives the value that appears after the
  // next edge; a write frame therefore spends one extra SEND cycle raising SS_n.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 4'd1;
    cmd_d       = cmd_q;
    shift_d     = shift_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    ss_n_d      = 1'b0;
    mosi_d      = 1'b0;
    frame       = {cmd_q[9], cmd_q};

    unique case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        cnt_d  = '0;
        if (cmd.cmd_valid) begin
          cmd_d   = cmd.cmd_data;
          state_d = SEND;
        end
      end

      SEND: begin
        if (cnt_q <= SEND_LAST_BIT) begin
          mosi_d = frame[SEND_LAST_BIT - cnt_q];
        end
        if (cnt_q == SEND_LAST_BIT && cmd_q[9:8] == 2'b11) begin
          state_d = (RD_GAP == 0) ? RECV : GAP;
          cnt_d   = '0;
        end else if (cnt_q == SEND_LAST) begin
          ss_n_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end

      RECV: begin
        if (cnt_q == RECV_LAST) begin
          ss_n_d      = 1'b1;
          rsp_data_d  = shift_q;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
        end else begin
          shift_d = {shift_q[6:0], MISO};
        end
      end

      default: begin
        ss_n_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      shift_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
    end
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign cmd.busy      = (state_q != IDLE);
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_data  = rsp_data_q;
  assign SS_n          = ss_n_q;
  assign MOSI          = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural SPI slave with RAM answers frames, and a
// transaction-level reference predicts frame contents, lengths and read replies.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int G = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic MISO  = 1'b0;
  logic SS_n, MOSI;

  spi_master_if bus ();

  spi_master #(.RD_GAP(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (bus),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  always #5 clk = ~clk;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int inv_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave side: RAM contents evolve only from what actually arrives on MOSI.
  logic [7:0]  smem [256];
  logic [7:0]  s_waddr = '0, s_raddr = '0;
  bit          in_frame = 1'b0;
  int          fidx, fstart, k;
  logic [10:0] fbits;
  int          f_len_q[$], f_start_q[$], f_end_q[$];
  logic [10:0] f_bits_q[$];
  logic [7:0]  r_data_q[$];
  int          r_cyc_q[$];

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      r_data_q.push_back(bus.rsp_data);
      r_cyc_q.push_back(cyc);
    end
    if (bus.cmd_ready !== ~bus.busy) inv_err++;
    if (SS_n === 1'b0) begin
      if (bus.busy !== 1'b1) inv_err++;
      if (!in_frame) begin
        in_frame = 1'b1;
        fidx     = 0;
        fstart   = cyc;
        fbits    = '0;
      end
      if (fidx < 11) fbits = {fbits[9:0], MOSI};
      else if (MOSI !== 1'b0) inv_err++;
      MISO = 1'($urandom);
      if (fidx >= 10 && fbits[9:8] == 2'b11) begin
        k = fidx - 10 - G;
        if (k >= 0 && k < 8) MISO = smem[s_raddr][7-k];
      end
      fidx++;
    end else begin
      if (MOSI !== 1'b0) inv_err++;
      if (in_frame) begin
        in_frame = 1'b0;
        f_len_q.push_back(fidx);
        f_start_q.push_back(fstart);
        f_end_q.push_back(cyc);
        f_bits_q.push_back(fbits);
        if (fidx >= 11) begin
          case (fbits[9:8])
            2'b00:   s_waddr = fbits[7:0];
            2'b01:   smem[s_waddr] = fbits[7:0];
            2'b10:   s_raddr = fbits[7:0];
            default: ;
          endcase
        end
      end
      MISO = 1'($urandom);
    end
  end

  // Transaction-level reference of the slave RAM.
  logic [7:0] ref_mem [256];
  logic [7:0] ref_waddr = '0, ref_raddr = '0;
  int acc_cyc, last_start, last_end;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [9:0] w, input bit hold);
    bit ready_now, done;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = w;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      ready_now = bus.cmd_ready;
      tick();
      if (ready_now) done = 1'b1;
    end
    if (!hold) bus.cmd_valid = 1'b0;
    chk("accept", 32'(done), 32'd1);
    acc_cyc = cyc;
    case (w[9:8])
      2'b00:   ref_waddr = w[7:0];
      2'b01:   ref_mem[ref_waddr] = w[7:0];
      2'b10:   ref_raddr = w[7:0];
      default: ;
    endcase
  endtask

  task automatic check_frame(input logic [9:0] w, input int acc, input logic [7:0] exp_rsp);
    int n;
    bit rd;
    rd = (w[9:8] == 2'b11);
    n  = 0;
    while (f_len_q.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    if (f_len_q.size() == 0) begin
      chk("frame_timeout", 32'd0, 32'd1);
      return;
    end
    last_start = f_start_q.pop_front();
    last_end   = f_end_q.pop_front();
    chk("frame_bits", 32'(f_bits_q.pop_front()), 32'({w[9], w}));
    chk("frame_len", f_len_q.pop_front(), rd ? 19 + G : 11);
    chk("frame_start", last_start - acc, 1);
    if (rd) begin
      if (r_data_q.size() == 0) begin
        chk("rsp_missing", 32'd0, 32'd1);
      end else begin
        chk("rsp_data", 32'(r_data_q.pop_front()), 32'(exp_rsp));
        chk("rsp_latency", r_cyc_q.pop_front() - acc, 20 + G);
      end
    end else begin
      chk("no_rsp", r_data_q.size(), 0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [9:0] w, w3;
    logic [7:0] exp;
    int a0, a1, a2, a3, e0, n, viol, len;

    for (int i = 0; i < 256; i++) begin
      smem[i]    = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;

    // Reset values appear without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ss_n", 32'(SS_n), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Write-address frame: MOSI 0,0,0,1,0,1,0,0,1,0,1.
    issue(10'h0A5, 1'b0);
    check_frame(10'h0A5, acc_cyc, 8'h00);
    repeat (3) tick();

    // Read-data frame from address 0 (RAM preset 8'h3C there).
    issue(10'h300, 1'b0);
    check_frame(10'h300, acc_cyc, 8'h3C);
    repeat (2) tick();

    // Back-to-back with cmd_valid held high.
    w3 = {2'b11, 8'($urandom)};
    issue(10'h012, 1'b1); a0 = acc_cyc;
    issue(10'h1FF, 1'b1); a1 = acc_cyc;
    issue(10'h212, 1'b1); a2 = acc_cyc;
    issue(w3, 1'b0);      a3 = acc_cyc;
    chk("b2b_acc01", a1 - a0, 13);
    chk("b2b_acc12", a2 - a1, 13);
    chk("b2b_acc23", a3 - a2, 13);
    check_frame(10'h012, a0, 8'h00); e0 = last_end;
    check_frame(10'h1FF, a1, 8'h00);
    chk("b2b_gap01", last_start - e0, 2); e0 = last_end;
    check_frame(10'h212, a2, 8'h00);
    chk("b2b_gap12", last_start - e0, 2); e0 = last_end;
    check_frame(w3, a3, 8'hFF);
    chk("b2b_gap23", last_start - e0, 2);
    repeat (2) tick();

    // Busy isolation: command port churns during a write frame.
    w = {1'b0, 1'($urandom), 8'($urandom)};
    issue(w, 1'b0);
    a0 = acc_cyc;
    viol = 0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      if (bus.cmd_ready !== 1'b0) viol++;
      bus.cmd_data  = 10'($urandom);
      bus.cmd_valid = 1'($urandom);
      tick();
      n++;
    end
    bus.cmd_valid = 1'b0;
    chk("iso_ready_low", viol, 0);
    chk("iso_busy_cycles", n, 12);
    check_frame(w, a0, 8'h00);
    repeat (4) tick();
    chk("iso_no_extra_frame", f_len_q.size() + (bus.busy === 1'b1 ? 1 : 0), 0);

    // Randomised command mix against the reference RAM.
    for (int i = 0; i < 24; i++) begin
      w   = 10'($urandom);
      exp = ref_mem[ref_raddr];
      issue(w, 1'b0);
      check_frame(w, acc_cyc, exp);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset during the 5th bit of a read-data frame.
    w = {2'b11, 8'($urandom)};
    issue(w, 1'b0);
    a0 = acc_cyc;
    n = 0;
    while (cyc < a0 + 5 && n < 20) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", 32'(SS_n), 32'd1);
    chk("mid_rst_mosi", 32'(MOSI), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_rsp_data", 32'(bus.rsp_data), 32'h00);
    repeat (3) tick();
    rst_n = 1'b1;
    n = 0;
    while (f_len_q.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    chk("abort_recorded", f_len_q.size(), 1);
    if (f_len_q.size() != 0) begin
      len = f_len_q.pop_front();
      void'(f_start_q.pop_front());
      void'(f_end_q.pop_front());
      void'(f_bits_q.pop_front());
      chk("abort_short", 32'(len < 11), 32'd1);
    end
    chk("abort_no_rsp", r_data_q.size(), 0);
    issue(10'h0A5, 1'b0);
    check_frame(10'h0A5, acc_cyc, 8'h00);

    repeat (5) tick();
    chk("stray_rsp", r_data_q.size(), 0);
    chk("invariants", inv_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
